// File: rtl/memory_island_dma_engine.sv
// Descriptor-driven DMA engine: copies len beats from src to dst (or fills dst with a pattern)
// over split read/write request channels. Fill mode exists only when MEMORY_ISLAND_DMA_FILL_EN is defined.
module memory_island_dma_engine #(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned LenWidth    = 16,
   parameter int unsigned BufferDepth = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   desc_valid_i,
   output logic                   desc_ready_o,
   input  logic [AddrWidth-1:0]   desc_src_i,
   input  logic [AddrWidth-1:0]   desc_dst_i,
   input  logic [LenWidth-1:0]    desc_len_i,
   input  logic                   desc_fill_i,
   input  logic [DataWidth-1:0]   desc_pattern_i,
   output logic                   done_o,
   output logic                   busy_o,
   output logic                   rd_req_o,
   input  logic                   rd_gnt_i,
   output logic [AddrWidth-1:0]   rd_addr_o,
   input  logic                   rd_rvalid_i,
   input  logic [DataWidth-1:0]   rd_rdata_i,
   output logic                   wr_req_o,
   input  logic                   wr_gnt_i,
   output logic [AddrWidth-1:0]   wr_addr_o,
   output logic [DataWidth-1:0]   wr_wdata_o,
   output logic [DataWidth/8-1:0] wr_strb_o,
   input  logic                   wr_rvalid_i
);

   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned PtrWidth  = $clog2(BufferDepth);
   localparam int unsigned CntWidth  = $clog2(BufferDepth + 1);
   localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(BeatBytes);
   localparam logic [PtrWidth-1:0]  PtrLast  = PtrWidth'(BufferDepth - 1);
   localparam logic [CntWidth:0]    Credits  = (CntWidth + 1)'(BufferDepth);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_ACK
   } state_e;

   state_e               r_state;
   logic [AddrWidth-1:0] r_rd_addr;
   logic [AddrWidth-1:0] r_wr_addr;
   logic [LenWidth-1:0]  r_len;
   logic [LenWidth-1:0]  r_rd_issued;
   logic [LenWidth-1:0]  r_wr_issued;
   logic [LenWidth-1:0]  r_ack_cnt;
   logic [CntWidth-1:0]  r_rd_outstanding;
   logic [CntWidth-1:0]  r_fifo_count;
   logic [PtrWidth-1:0]  r_fifo_wptr;
   logic [PtrWidth-1:0]  r_fifo_rptr;
   logic [DataWidth-1:0] r_fifo_mem [BufferDepth];
   logic                 r_done;

   logic                 w_desc_fire;
   logic                 w_fill;
   logic [DataWidth-1:0] w_pattern;
   logic                 w_rd_req;
   logic                 w_rd_fire;
   logic                 w_push;
   logic                 w_wr_req;
   logic                 w_wr_fire;
   logic                 w_pop;
   logic                 w_ack;
   logic [LenWidth-1:0]  w_ack_next;

   assign w_desc_fire = desc_valid_i && (r_state == ST_IDLE);

`ifdef MEMORY_ISLAND_DMA_FILL_EN
   logic                 r_fill;
   logic [DataWidth-1:0] r_pattern;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fill    <= 1'b0;
         r_pattern <= '0;
      end else if (w_desc_fire) begin
         r_fill    <= desc_fill_i;
         r_pattern <= desc_pattern_i;
      end
   end

   assign w_fill    = r_fill;
   assign w_pattern = r_pattern;
`else
   logic w_unused_fill;
   assign w_unused_fill = desc_fill_i ^ (^desc_pattern_i);
   assign w_fill        = 1'b0;
   assign w_pattern     = '0;
`endif

   // Read credit: in-flight reads plus buffered beats never exceed the FIFO depth.
   assign w_rd_req  = (r_state == ST_RUN) && !w_fill && (r_rd_issued < r_len) &&
                      (({1'b0, r_rd_outstanding} + {1'b0, r_fifo_count}) < Credits);
   assign w_rd_fire = w_rd_req && rd_gnt_i;
   // Responses are accepted only against reads this engine still has in flight.
   assign w_push    = rd_rvalid_i && (r_rd_outstanding != '0);

   assign w_wr_req  = (r_state == ST_RUN) && (r_wr_issued < r_len) &&
                      (w_fill || (r_fifo_count != '0));
   assign w_wr_fire = w_wr_req && wr_gnt_i;
   assign w_pop     = w_wr_fire && !w_fill;

   assign w_ack      = wr_rvalid_i && (r_ack_cnt < r_wr_issued);
   assign w_ack_next = r_ack_cnt + LenWidth'(w_ack);

   assign desc_ready_o = (r_state == ST_IDLE);
   assign busy_o       = (r_state != ST_IDLE);
   assign done_o       = r_done;
   assign rd_req_o     = w_rd_req;
   assign rd_addr_o    = r_rd_addr;
   assign wr_req_o     = w_wr_req;
   assign wr_addr_o    = r_wr_addr;
   assign wr_wdata_o   = w_fill ? w_pattern : r_fifo_mem[r_fifo_rptr];
   assign wr_strb_o    = '1;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_mem[r_fifo_wptr] <= rd_rdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= ST_IDLE;
         r_rd_addr        <= '0;
         r_wr_addr        <= '0;
         r_len            <= '0;
         r_rd_issued      <= '0;
         r_wr_issued      <= '0;
         r_ack_cnt        <= '0;
         r_rd_outstanding <= '0;
         r_fifo_count     <= '0;
         r_fifo_wptr      <= '0;
         r_fifo_rptr      <= '0;
         r_done           <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (w_rd_fire) begin
            r_rd_addr   <= r_rd_addr + AddrStep;
            r_rd_issued <= r_rd_issued + LenWidth'(1);
         end
         if (w_wr_fire) begin
            r_wr_addr   <= r_wr_addr + AddrStep;
            r_wr_issued <= r_wr_issued + LenWidth'(1);
         end

         r_rd_outstanding <= r_rd_outstanding + CntWidth'(w_rd_fire) - CntWidth'(w_push);
         r_fifo_count     <= r_fifo_count + CntWidth'(w_push) - CntWidth'(w_pop);

         if (w_push) begin
            r_fifo_wptr <= (r_fifo_wptr == PtrLast) ? '0 : r_fifo_wptr + PtrWidth'(1);
         end
         if (w_pop) begin
            r_fifo_rptr <= (r_fifo_rptr == PtrLast) ? '0 : r_fifo_rptr + PtrWidth'(1);
         end

         r_ack_cnt <= w_ack_next;

         unique case (r_state)
            ST_IDLE: begin
               if (w_desc_fire) begin
                  if (desc_len_i == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state     <= ST_RUN;
                     r_rd_addr   <= desc_src_i;
                     r_wr_addr   <= desc_dst_i;
                     r_len       <= desc_len_i;
                     r_rd_issued <= '0;
                     r_wr_issued <= '0;
                     r_ack_cnt   <= '0;
                  end
               end
            end
            ST_RUN: begin
               if (w_wr_fire && (r_wr_issued == r_len - LenWidth'(1))) begin
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (w_ack_next == r_len) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_island_dma_engine.sv
// Bench for memory_island_dma_engine: a randomized memory responder feeds the engine while a
// scoreboard of expected writes (built from each descriptor) is checked against every granted write.
module tb_memory_island_dma_engine;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned LW = 16;
   localparam int unsigned BD = 4;
`ifdef MEMORY_ISLAND_DMA_FILL_EN
   localparam bit FillEn = 1'b1;
`else
   localparam bit FillEn = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          desc_valid_i;
   logic          desc_ready_o;
   logic [AW-1:0] desc_src_i;
   logic [AW-1:0] desc_dst_i;
   logic [LW-1:0] desc_len_i;
   logic          desc_fill_i;
   logic [DW-1:0] desc_pattern_i;
   logic          done_o;
   logic          busy_o;
   logic          rd_req_o;
   logic          rd_gnt_i;
   logic [AW-1:0] rd_addr_o;
   logic          rd_rvalid_i;
   logic [DW-1:0] rd_rdata_i;
   logic          wr_req_o;
   logic          wr_gnt_i;
   logic [AW-1:0] wr_addr_o;
   logic [DW-1:0] wr_wdata_o;
   logic [DW/8-1:0] wr_strb_o;
   logic          wr_rvalid_i;

   memory_island_dma_engine #(
      .AddrWidth  (AW),
      .DataWidth  (DW),
      .LenWidth   (LW),
      .BufferDepth(BD)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .desc_valid_i  (desc_valid_i),
      .desc_ready_o  (desc_ready_o),
      .desc_src_i    (desc_src_i),
      .desc_dst_i    (desc_dst_i),
      .desc_len_i    (desc_len_i),
      .desc_fill_i   (desc_fill_i),
      .desc_pattern_i(desc_pattern_i),
      .done_o        (done_o),
      .busy_o        (busy_o),
      .rd_req_o      (rd_req_o),
      .rd_gnt_i      (rd_gnt_i),
      .rd_addr_o     (rd_addr_o),
      .rd_rvalid_i   (rd_rvalid_i),
      .rd_rdata_i    (rd_rdata_i),
      .wr_req_o      (wr_req_o),
      .wr_gnt_i      (wr_gnt_i),
      .wr_addr_o     (wr_addr_o),
      .wr_wdata_o    (wr_wdata_o),
      .wr_strb_o     (wr_strb_o),
      .wr_rvalid_i   (wr_rvalid_i)
   );

   always #5 clk_i = ~clk_i;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];

   int unsigned rd_pct = 100;
   int unsigned wr_pct = 100;
   logic wr_block     = 1'b0;
   logic fill_active  = 1'b0;
   logic inject_stray = 1'b0;
   int xfer_rd = 0, xfer_wr = 0, xfer_acks = 0;
   int first_rd_cyc = -1, first_wreq_cyc = -1;
   int cyc = 0, done_cnt = 0, req_seen = 0;

   function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
      return {~a ^ 32'h5A5A_0F0F, a * 32'h9E37_79B1};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      check({name, "_outs"}, {59'd0, rd_req_o, wr_req_o, done_o, busy_o, desc_ready_o}, 64'd1);
   endtask

   // Reference model: the write stream a descriptor must produce, in order.
   task automatic issue(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                        input logic fill, input logic [DW-1:0] pat);
      logic fill_eff;
      fill_eff = FillEn && fill;
      for (int i = 0; i < len; i++) begin
         wr_t e;
         e.addr = dst + 32'(8 * i);
         e.data = fill_eff ? pat : src_word(src + 32'(8 * i));
         exp_q.push_back(e);
      end
      xfer_rd = 0; xfer_wr = 0; xfer_acks = 0;
      first_rd_cyc = -1; first_wreq_cyc = -1;
      fill_active = fill_eff;
      check("desc_ready", desc_ready_o, 1);
      desc_valid_i   = 1'b1;
      desc_src_i     = src;
      desc_dst_i     = dst;
      desc_len_i     = LW'(len);
      desc_fill_i    = fill;
      desc_pattern_i = pat;
      @(negedge clk_i);
      desc_valid_i   = 1'b0;
      desc_fill_i    = 1'b0;
      desc_pattern_i = '0;
   endtask

   task automatic wait_done(input int len, input string name);
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 3000) begin
         @(negedge clk_i);
         n++;
      end
      check({name, "_done_seen"}, done_o, 1);
      if (done_o === 1'b1) begin
         check({name, "_acks_at_done"}, xfer_acks, len);
         check({name, "_writes"}, xfer_wr, len);
         check({name, "_sb_empty"}, exp_q.size(), 0);
      end
      exp_q.delete();
      @(negedge clk_i);
      check({name, "_done_pulse"}, done_o, 0);
      check({name, "_busy_end"}, busy_o, 0);
   endtask

   // Memory responder and monitor: grants, one-cycle read data and write acks, scoreboard pops.
   initial begin : bus
      logic          p_rd_req, p_rd_gnt, p_wr_req, p_wr_gnt;
      logic [AW-1:0] p_rd_addr, p_wr_addr;
      logic [DW-1:0] p_wr_data;
      wr_t           e;
      p_rd_req = 0; p_rd_gnt = 0; p_wr_req = 0; p_wr_gnt = 0;
      p_rd_addr = '0; p_wr_addr = '0; p_wr_data = '0;
      rd_gnt_i = 0; wr_gnt_i = 0; rd_rvalid_i = 0; wr_rvalid_i = 0; rd_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (done_o === 1'b1) done_cnt++;
         if (rd_req_o || wr_req_o) req_seen++;
         rd_rvalid_i = 1'b0;
         wr_rvalid_i = 1'b0;
         rd_rdata_i  = '0;
         if (p_rd_req && p_rd_gnt) begin
            rd_rvalid_i = 1'b1;
            rd_rdata_i  = src_word(p_rd_addr);
         end
         if (p_wr_req && p_wr_gnt) begin
            wr_rvalid_i = 1'b1;
            xfer_acks++;
         end
         if (inject_stray) begin
            rd_rvalid_i  = 1'b1;
            rd_rdata_i   = 64'hBAD0_BAD0_BAD0_BAD0;
            wr_rvalid_i  = 1'b1;
            inject_stray = 1'b0;
         end
         if (rst_i) begin
            rd_gnt_i = 1'b0; wr_gnt_i = 1'b0;
            p_rd_req = 0; p_rd_gnt = 0; p_wr_req = 0; p_wr_gnt = 0;
         end else begin
            if (p_rd_req && !p_rd_gnt && rd_req_o)
               check("rd_addr_stable", rd_addr_o, p_rd_addr);
            if (p_wr_req && !p_wr_gnt && wr_req_o) begin
               check("wr_addr_stable", wr_addr_o, p_wr_addr);
               check("wr_data_stable", wr_wdata_o, p_wr_data);
            end
            rd_gnt_i = ($urandom_range(99, 0) < rd_pct);
            wr_gnt_i = !wr_block && ($urandom_range(99, 0) < wr_pct);
            if (fill_active && busy_o) check("fill_no_rd_req", rd_req_o, 0);
            if (rd_req_o && rd_gnt_i) begin
               check("rd_credit", (xfer_rd - xfer_wr) < BD, 1);
               if (first_rd_cyc < 0) first_rd_cyc = cyc;
               xfer_rd++;
            end
            if (wr_req_o && first_wreq_cyc < 0) first_wreq_cyc = cyc;
            if (wr_req_o && wr_gnt_i) begin
               check("wr_strb", wr_strb_o, 64'hFF);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL wr_unexpected actual addr=0x%0h required=no write", wr_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  checks--;
                  check("wr_addr", wr_addr_o, e.addr);
                  check("wr_data", wr_wdata_o, e.data);
               end
               xfer_wr++;
            end
            p_rd_req = rd_req_o; p_rd_gnt = rd_gnt_i; p_rd_addr = rd_addr_o;
            p_wr_req = wr_req_o; p_wr_gnt = wr_gnt_i;
            p_wr_addr = wr_addr_o; p_wr_data = wr_wdata_o;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int n, snap, dsnap, len;
      logic [AW-1:0] src, dst;
      rst_i = 1'b1;
      desc_valid_i = 1'b0; desc_src_i = '0; desc_dst_i = '0; desc_len_i = '0;
      desc_fill_i = 1'b0; desc_pattern_i = '0;
      repeat (3) @(negedge clk_i);
      check_reset("reset");
      rst_i = 1'b0;
      @(negedge clk_i);

      issue(32'h1000, 32'h2000, 8, 1'b0, '0);
      wait_done(8, "copy");
      check("copy_latency", first_wreq_cyc - first_rd_cyc, 2);

      wr_block = 1'b1;
      issue(32'h1000, 32'h2000, 8, 1'b0, '0);
      repeat (20) @(negedge clk_i);
      check("bp_reads_capped", xfer_rd, BD);
      check("bp_no_writes", xfer_wr, 0);
      wr_block = 1'b0;
      wait_done(8, "bp");

      issue(32'h4000, 32'h3000, 5, 1'b1, 64'hDEADBEEF_CAFEF00D);
      wait_done(5, "fill");
      check("fill_reads", xfer_rd, FillEn ? 0 : 5);

      snap = req_seen;
      issue(32'h1000, 32'h2000, 0, 1'b0, '0);
      check("zero_done", done_o, 1);
      check("zero_busy0", busy_o, 0);
      @(negedge clk_i);
      check("zero_done_pulse", done_o, 0);
      check("zero_busy1", busy_o, 0);
      repeat (3) @(negedge clk_i);
      check("zero_no_req", req_seen - snap, 0);

      issue(32'h1000, 32'h2000, 8, 1'b0, '0);
      n = 0;
      while (xfer_wr < 3 && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      check("abort_reach3", xfer_wr >= 3, 1);
      @(negedge clk_i);
      dsnap = done_cnt;
      rst_i = 1'b1;
      #1;
      check_reset("abort_reset");
      repeat (2) @(negedge clk_i);
      check_reset("abort_hold");
      rst_i = 1'b0;
      exp_q.delete();
      inject_stray = 1'b1;
      repeat (5) @(negedge clk_i);
      check("abort_no_done", done_cnt - dsnap, 0);
      check("abort_idle", {busy_o, desc_ready_o}, 2'b01);
      issue(32'h5000, 32'h6000, 2, 1'b0, '0);
      wait_done(2, "post_abort");

      issue(32'h1000, 32'hFFFF_FFF8, 2, 1'b0, '0);
      wait_done(2, "wrap");

      for (int t = 0; t < 12; t++) begin
         rd_pct = $urandom_range(100, 30);
         wr_pct = $urandom_range(100, 30);
         src = $urandom() & 32'hFFFF_FFF8;
         dst = $urandom() & 32'hFFFF_FFF8;
         len = $urandom_range(12, 1);
         issue(src, dst, len, 1'(($urandom_range(1, 0))), {$urandom(), $urandom()});
         wait_done(len, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_island_dma_engine.md
MEMORY_ISLAND_DMA_ENGINE -- requirements
Module: memory_island_dma_engine

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, byte address width.
REQ-002 SHALL have parameter DataWidth, default 64, port data width; a power of two, at least 32.
REQ-003 SHALL have parameter LenWidth, default 16, width of the beat count.
REQ-004 SHALL have parameter BufferDepth, default 4, read-data FIFO depth; at least 2.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake.
- desc_src_i, desc_dst_i  in  AddrWidth  word-aligned source and destination.
- desc_len_i  in  LenWidth  number of beats.
- desc_fill_i  in  1  fill mode.
- desc_pattern_i  in  DataWidth  fill word.
- done_o  out  1  transfer-complete pulse.
- busy_o  out  1  engine not IDLE.
- rd_req_o / rd_gnt_i, rd_addr_o  out/in, out  1, AddrWidth  read request channel.
- rd_rvalid_i, rd_rdata_i  in  1, DataWidth  read response.
- wr_req_o / wr_gnt_i, wr_addr_o, wr_wdata_o, wr_strb_o  out/in, out  1, AddrWidth, DataWidth, DataWidth/8  write request channel.
- wr_rvalid_i  in  1  write acknowledge.

Function
REQ-007 SHALL implement the states IDLE, RUN and ACK; desc_ready_o SHALL be 1 only in IDLE.
REQ-008 On a descriptor handshake, the engine SHALL latch the descriptor and go to RUN; if desc_len_i = 0, it SHALL instead stay in IDLE and assert done_o in the next cycle with no bus activity.
REQ-009 Addresses SHALL advance by DataWidth/8 per granted beat, wrapping modulo 2^AddrWidth.
REQ-010 rd_req_o SHALL be asserted only while issued reads are fewer than len and (outstanding reads + FIFO occupancy) < BufferDepth; this credit rule means the FIFO never overflows.
REQ-011 Each rd_rvalid_i SHALL push rd_rdata_i into the FIFO in the same cycle; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-012 In copy mode, wr_req_o SHALL be asserted while the FIFO is non-empty and issued writes are fewer than len; wr_wdata_o SHALL be the FIFO head, popped on wr_gnt_i.
REQ-013 In fill mode, rd_req_o SHALL stay 0 and wr_req_o SHALL be asserted until len writes are granted, with wr_wdata_o = pattern.
REQ-014 wr_strb_o SHALL be all ones.
REQ-015 Request address and data SHALL stay stable while the request is high and not granted.
REQ-016 RUN SHALL go to ACK in the cycle after the len-th write grant.
REQ-017 ACK SHALL go to IDLE when the write-acknowledge count reaches len, with done_o high for exactly one cycle.
REQ-018 Write acknowledges that arrive during RUN SHALL be counted.
REQ-019 busy_o SHALL be 1 in RUN and ACK.
REQ-020 Latency: a read grant at cycle t with rvalid at t+1 SHALL allow the earliest write request at t+2.

Reset
REQ-021 While rst_i is high, the engine SHALL be in IDLE with the FIFO and all counters cleared.
REQ-022 While rst_i is high, rd_req_o, wr_req_o, done_o and busy_o SHALL be 0 and desc_ready_o SHALL be 1.
REQ-023 Assertion of rst_i mid-transfer SHALL abort the transfer without a done_o pulse; responses that arrive after reset for requests issued before it SHALL be ignored.

Configuration
REQ-024 The fill feature SHALL be controlled by the macro MEMORY_ISLAND_DMA_FILL_EN.
REQ-025 With MEMORY_ISLAND_DMA_FILL_EN defined, desc_fill_i SHALL select fill mode.
REQ-026 Without MEMORY_ISLAND_DMA_FILL_EN, desc_fill_i and desc_pattern_i SHALL be ignored and every descriptor SHALL be treated as a copy.

Verification
REQ-027 Copy test: src=0x1000, dst=0x2000, len=8, grants always high, rvalid one cycle after grant -> 8 writes to 0x2000..0x2038 with data matching the source, and done_o after the 8th acknowledge.
REQ-028 Backpressure test: same copy with wr_gnt_i held 0 for 20 cycles -> reads stop after 4 beats (BufferDepth), no data is lost, and the 8 writes complete in order.
REQ-029 Fill test (macro defined): dst=0x3000, len=5, pattern=0xDEADBEEF_CAFEF00D -> no read requests and 5 writes carrying the pattern; with the macro undefined, the same descriptor performs a copy.
REQ-030 Zero-length test: len=0 -> done_o in the next cycle, busy_o stays 0, and no requests are issued.
REQ-031 Abort test: rst_i pulsed after 3 of 8 writes -> all outputs return to their reset values with no done_o; a following len=2 copy completes normally.
REQ-032 Wrap test: dst=2^AddrWidth-8, len=2 -> write addresses 0xFFFFFFF8 then 0x00000000.
